// File: rtl/ps2_note_decoder_if.sv
// Scan-code byte stream from the PS/2 receiver.
// One strobe per byte, no backpressure.
interface ps2_note_decoder_if;
  logic [7:0] iScanCode;
  logic       iScanValid;

  modport master (output iScanCode, output iScanValid);
  modport slave  (input  iScanCode, input  iScanValid);
endinterface

// File: rtl/ps2_note_decoder.sv
// Set-2 scan-code decoder: make/break prefix tracking,
// note level output and one-shot control key pulses.
module ps2_note_decoder (
  input  logic                 iClock,
  input  logic                 iResetn,
  ps2_note_decoder_if.slave    scan,
  output logic [3:0]           oNote,
  output logic                 oNoteIn,
  output logic                 oOctavePlus,
  output logic                 oOctaveMinus,
  output logic                 oADSRPlus,
  output logic                 oADSRMinus,
  output logic [2:0]           oADSRSelector
);

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_t;

  state_t     state, state_n;
  logic [3:0] note, note_n;
  logic       note_in, note_in_n;
  logic [3:0] pulse, pulse_n;
  logic [3:0] held, held_n;
  logic [1:0] sel, sel_n;

  logic       is_note, is_ctl, is_sel;
  logic [3:0] idx;
  logic [1:0] ctl;
  logic [1:0] sel_v;
  logic       do_make, do_brk;

  // pulse/held bit order: 0 oct-, 1 oct+, 2 adsr-, 3 adsr+
  always_comb begin
    is_note = 1'b0;
    is_ctl  = 1'b0;
    is_sel  = 1'b0;
    idx     = 4'd0;
    ctl     = 2'd0;
    sel_v   = 2'd0;
    case (scan.iScanCode)
      8'h1C: begin is_note = 1'b1; idx = 4'd0;  end
      8'h1D: begin is_note = 1'b1; idx = 4'd1;  end
      8'h1B: begin is_note = 1'b1; idx = 4'd2;  end
      8'h24: begin is_note = 1'b1; idx = 4'd3;  end
      8'h23: begin is_note = 1'b1; idx = 4'd4;  end
      8'h2B: begin is_note = 1'b1; idx = 4'd5;  end
      8'h2C: begin is_note = 1'b1; idx = 4'd6;  end
      8'h34: begin is_note = 1'b1; idx = 4'd7;  end
      8'h35: begin is_note = 1'b1; idx = 4'd8;  end
      8'h33: begin is_note = 1'b1; idx = 4'd9;  end
      8'h3C: begin is_note = 1'b1; idx = 4'd10; end
      8'h3B: begin is_note = 1'b1; idx = 4'd11; end
      8'h1A: begin is_ctl = 1'b1; ctl = 2'd0; end
      8'h22: begin is_ctl = 1'b1; ctl = 2'd1; end
      8'h21: begin is_ctl = 1'b1; ctl = 2'd2; end
      8'h2A: begin is_ctl = 1'b1; ctl = 2'd3; end
      8'h16: begin is_sel = 1'b1; sel_v = 2'd0; end
      8'h1E: begin is_sel = 1'b1; sel_v = 2'd1; end
      8'h26: begin is_sel = 1'b1; sel_v = 2'd2; end
      8'h25: begin is_sel = 1'b1; sel_v = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    state_n   = state;
    note_n    = note;
    note_in_n = note_in;
    pulse_n   = 4'd0;
    held_n    = held;
    sel_n     = sel;
    do_make   = 1'b0;
    do_brk    = 1'b0;
    if (scan.iScanValid) begin
      unique case (state)
        IDLE: begin
          if (scan.iScanCode == 8'hF0)      state_n = BRK;
          else if (scan.iScanCode == 8'hE0) state_n = EXT;
          else                              do_make = 1'b1;
        end
        BRK: begin
          if (scan.iScanCode == 8'hE0)      state_n = EXT;
          else if (scan.iScanCode != 8'hF0) begin
            do_brk  = 1'b1;
            state_n = IDLE;
          end
        end
        EXT: begin
          if (scan.iScanCode == 8'hF0)      state_n = EXT_BRK;
          else if (scan.iScanCode != 8'hE0) state_n = IDLE;
        end
        EXT_BRK: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    if (do_make) begin
      if (is_note) begin
        note_n    = idx;
        note_in_n = 1'b1;
      end
      if (is_ctl) begin
        pulse_n[ctl] = ~held[ctl];
        held_n[ctl]  = 1'b1;
      end
      if (is_sel) sel_n = sel_v;
    end
    if (do_brk) begin
      // note stays put on release so the display erases the right key
      if (is_note && idx == note && note_in) note_in_n = 1'b0;
      if (is_ctl) held_n[ctl] = 1'b0;
    end
  end

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state   <= IDLE;
      note    <= 4'd0;
      note_in <= 1'b0;
      pulse   <= 4'd0;
      held    <= 4'd0;
      sel     <= 2'd0;
    end else begin
      state   <= state_n;
      note    <= note_n;
      note_in <= note_in_n;
      pulse   <= pulse_n;
      held    <= held_n;
      sel     <= sel_n;
    end
  end

  assign oNote         = note;
  assign oNoteIn       = note_in;
  assign oOctaveMinus  = pulse[0];
  assign oOctavePlus   = pulse[1];
  assign oADSRMinus    = pulse[2];
  assign oADSRPlus     = pulse[3];
  assign oADSRSelector = {1'b0, sel};

endmodule
